// File: rtl/mips_multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath: decodes the IR opcode, steps each
// instruction through its states and drives all datapath enables and mux selects.
module mips_multicycle_control #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic                 iord,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_eq,
   output logic                 pc_write_ne,
   output logic [1:0]           pc_source,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           alu_op,
   output logic [1:0]           reg_dst,
   output logic [1:0]           mem_to_reg,
   output logic                 reg_write,
   output logic                 illegal_op,
   output logic [3:0]           state_out,
   output logic [CNT_WIDTH-1:0] instr_retired
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_IEX    = 4'd10,
      S_IWB    = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_eq;
      logic       pc_write_ne;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t               state_reg, state_next;
   logic [5:0]           op_q, op_next;
   ctrl_t                ctrl_reg, ctrl_next;
   logic                 illegal_reg, illegal_next;
   logic                 retire;
   logic [CNT_WIDTH-1:0] cnt_reg;

   // Moore control word for a given state; op is the opcode latched in DECODE.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_REX: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b111;
         end
         S_RWB: begin
            c.reg_dst   = 2'b01;
            c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a   = 1'b1;
            c.alu_op      = 3'b001;
            c.pc_source   = 2'b01;
            c.pc_write_eq = (op == OP_BEQ);
            c.pc_write_ne = (op == OP_BNE);
         end
         S_IEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (op)
               OP_ANDI: c.alu_op = 3'b010;
               OP_ORI:  c.alu_op = 3'b011;
               OP_LUI:  c.alu_op = 3'b100;
               default: c.alu_op = 3'b000;
            endcase
         end
         S_IWB: c.reg_write = 1'b1;
         S_JUMP: begin
            c.pc_source = 2'b10;
            c.pc_write  = 1'b1;
            if (op == OP_JAL) begin
               c.reg_dst    = 2'b10;
               c.mem_to_reg = 2'b10;
               c.reg_write  = 1'b1;
            end
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_next   = state_reg;
      op_next      = (state_reg == S_DECODE) ? opcode : op_q;
      illegal_next = 1'b0;
      retire       = 1'b0;
      case (state_reg)
         S_IDLE:  state_next = S_FETCH;
         S_FETCH: if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:                      state_next = S_MEMADR;
               OP_RTYPE:                          state_next = S_REX;
               OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_next = S_IEX;
               OP_J, OP_JAL:                      state_next = S_JUMP;
               default: begin
                  state_next   = S_FETCH;
                  illegal_next = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
         S_MEMWR: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_REX: state_next = S_RWB;
         S_IEX: state_next = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      ctrl_next = decode_ctrl(state_next, op_next);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         op_q        <= '0;
         ctrl_reg    <= '0;
         illegal_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         op_q        <= op_next;
         ctrl_reg    <= ctrl_next;
         illegal_reg <= illegal_next;
         if (retire)
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
   end

   // ir_write is only set in FETCH, so it doubles as the "in FETCH" qualifier for pc_write.
   assign ir_write      = ctrl_reg.ir_write & mem_ready;
   assign pc_write      = ctrl_reg.pc_write & (mem_ready | ~ctrl_reg.ir_write);
   assign mem_req       = ctrl_reg.mem_req;
   assign mem_write     = ctrl_reg.mem_write;
   assign iord          = ctrl_reg.iord;
   assign pc_write_eq   = ctrl_reg.pc_write_eq;
   assign pc_write_ne   = ctrl_reg.pc_write_ne;
   assign pc_source     = ctrl_reg.pc_source;
   assign alu_src_a     = ctrl_reg.alu_src_a;
   assign alu_src_b     = ctrl_reg.alu_src_b;
   assign alu_op        = ctrl_reg.alu_op;
   assign reg_dst       = ctrl_reg.reg_dst;
   assign mem_to_reg    = ctrl_reg.mem_to_reg;
   assign reg_write     = ctrl_reg.reg_write;
   assign illegal_op    = illegal_reg;
   assign state_out     = state_reg;
   assign instr_retired = cnt_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control with a 4-bit retire counter so wrap is reachable.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
   logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
   logic       alu_src_a, reg_write, illegal_op;
   logic [2:0] alu_op;
   logic [3:0] state_out;
   logic [3:0] instr_retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_multicycle_control #(.CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
      .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .illegal_op(illegal_op), .state_out(state_out),
      .instr_retired(instr_retired)
   );

   wire [23:0] all_outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_eq,
                           pc_write_ne, pc_source, alu_src_a, alu_src_b, alu_op,
                           reg_dst, mem_to_reg, reg_write, illegal_op, instr_retired[0]};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
      repeat (3) tick();
      chk("rst_state", state_out, 0);
      chk("rst_outs", all_outs, 0);
      chk("rst_cnt", instr_retired, 0);
      reset = 1'b1;
      #1 chk("idle_after_release", state_out, 0);

      // add (R-type)
      tick();
      chk("fetch_state", state_out, 1);
      chk("fetch_sig", {mem_req, iord, ir_write, pc_write, alu_src_a, alu_src_b, alu_op, pc_source}, 14'b1_0_1_1_0_01_000_00);
      tick();
      chk("add_decode", state_out, 2);
      chk("decode_sig", {mem_req, alu_src_a, alu_src_b, alu_op, reg_write}, 8'b0_0_11_000_0);
      tick();
      chk("add_rex", state_out, 7);
      chk("rex_sig", {alu_src_a, alu_src_b, alu_op, reg_write}, 7'b1_00_111_0);
      tick();
      chk("add_rwb", state_out, 8);
      chk("rwb_sig", {reg_write, reg_dst, mem_to_reg}, 5'b1_01_00);
      tick();
      chk("add_retire", {state_out, instr_retired}, {4'd1, 4'd1});

      // lw with stalls: FETCH held 3 cycles, MEMRD held 2
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("lw_fetch_stall", {state_out, mem_req, ir_write, pc_write}, {4'd1, 3'b100});
         if (i < 2) tick(); else begin @(posedge clk); #1; end
      end
      mem_ready = 1'b1;
      #1 chk("lw_fetch_go", {state_out, mem_req, ir_write, pc_write}, {4'd1, 3'b111});
      opcode = 6'h23;
      tick();
      chk("lw_decode", state_out, 2);
      tick();
      opcode = 6'h2B;  // change live opcode; MEMADR must use the latched one
      chk("lw_memadr", {state_out, alu_src_a, alu_src_b, alu_op}, {4'd3, 6'b1_10_000});
      tick();
      mem_ready = 1'b0;
      #1 chk("lw_memrd1", {state_out, mem_req, iord, mem_write}, {4'd4, 3'b110});
      tick();
      chk("lw_memrd2", {state_out, mem_req, iord}, {4'd4, 2'b11});
      tick();
      chk("lw_memrd3", {state_out, mem_req}, {4'd4, 1'b1});
      mem_ready = 1'b1;
      tick();
      chk("lw_memwb", {state_out, reg_write, reg_dst, mem_to_reg}, {4'd5, 5'b1_00_01});
      tick();
      chk("lw_retire", {state_out, instr_retired}, {4'd1, 4'd2});

      // beq then bne
      opcode = 6'h04;
      tick(); tick();
      chk("beq_branch", {state_out, pc_write, pc_write_eq, pc_write_ne, pc_source, alu_op, alu_src_a},
          {4'd9, 9'b0_1_0_01_001_1});
      tick();
      chk("beq_retire", instr_retired, 3);
      opcode = 6'h05;
      tick(); tick();
      chk("bne_branch", {state_out, pc_write, pc_write_eq, pc_write_ne, pc_source, alu_op},
          {4'd9, 8'b0_0_1_01_001});
      tick();
      chk("bne_retire", instr_retired, 4);

      // jal
      opcode = 6'h03;
      tick(); tick();
      chk("jal_jump", {state_out, pc_write, pc_source, reg_dst, mem_to_reg, reg_write},
          {4'd12, 8'b1_10_10_10_1});
      tick();
      chk("jal_retire", instr_retired, 5);

      // ori, lui
      opcode = 6'h0D;
      tick(); tick();
      chk("ori_iex", {state_out, alu_src_a, alu_src_b, alu_op}, {4'd10, 6'b1_10_011});
      tick();
      chk("ori_iwb", {state_out, reg_write, reg_dst, mem_to_reg}, {4'd11, 5'b1_00_00});
      tick();
      opcode = 6'h0F;
      tick(); tick();
      chk("lui_iex", {state_out, alu_op}, {4'd10, 3'b100});
      tick(); tick();
      chk("lui_retire", {state_out, instr_retired}, {4'd1, 4'd7});

      // illegal opcode
      opcode = 6'h3F;
      tick();
      chk("ill_decode", {state_out, illegal_op}, {4'd2, 1'b0});
      mem_ready = 1'b0;
      tick();
      chk("ill_pulse", {state_out, illegal_op, instr_retired}, {4'd1, 1'b1, 4'd7});
      tick();
      chk("ill_pulse_end", {state_out, illegal_op}, {4'd1, 1'b0});

      // sw stalled in MEMWR, then async reset
      mem_ready = 1'b1; opcode = 6'h2B;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      #1 chk("sw_memwr", {state_out, mem_req, mem_write, iord, reg_write}, {4'd6, 4'b1110});
      tick();
      chk("sw_stall", {state_out, mem_req, mem_write}, {4'd6, 2'b11});
      #2 reset = 1'b0;
      #1 chk("async_rst", {state_out, mem_req, mem_write, instr_retired}, {4'd0, 2'b00, 4'd0});
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = 1'b1; opcode = 6'h02;

      // 16 plain jumps wrap the 4-bit counter
      tick();
      for (int i = 0; i < 16; i++) begin
         tick(); tick();
         if (i == 0) chk("j_no_link", {state_out, pc_write, reg_write}, {4'd12, 2'b10});
         tick();
         if (i == 14) chk("cnt_15", instr_retired, 15);
      end
      chk("cnt_wrap", {state_out, instr_retired}, {4'd1, 4'd0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
